// File: rtl/chaos_xpander_stream.sv
// Streaming chaos expander: takes a CHAOS_W-bit seed, builds the
// CHAOS_W*CHAOS_W-bit self-modulated vector (optionally stride-permuted)
// and emits it as OUT_W-bit beats under valid/ready flow control.
module chaos_xpander_stream #(
    parameter int unsigned CHAOS_W = 16,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned STRIDE  = 37
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [CHAOS_W-1:0] i_chaos,
    input  logic               i_mode,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_valid,
    output logic               o_last,
    input  logic               i_ready
);

    localparam int unsigned L     = CHAOS_W * CHAOS_W;
    localparam int unsigned LW    = $clog2(L);
    localparam int unsigned NB    = L / OUT_W;
    localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

    // Parameter legality, caught at elaboration
    generate
        if ((CHAOS_W < 4) || ((CHAOS_W & (CHAOS_W - 1)) != 0)) begin : g_bad_chaos_w
            $error("chaos_xpander_stream: CHAOS_W must be a power of two >= 4");
        end
        if ((OUT_W == 0) || ((L % OUT_W) != 0)) begin : g_bad_out_w
            $error("chaos_xpander_stream: OUT_W must divide CHAOS_W*CHAOS_W");
        end
        if ((STRIDE % 2) == 0) begin : g_bad_stride
            $error("chaos_xpander_stream: STRIDE must be odd");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Self-modulation: row i is the seed itself when C[i]=1, its complement otherwise
    function automatic logic [L-1:0] expand_u(input logic [CHAOS_W-1:0] c);
        logic [L-1:0] u;
        u = '0;
        for (int unsigned i = 0; i < CHAOS_W; i++) begin
            for (int unsigned k = 0; k < CHAOS_W; k++) begin
                u[i*CHAOS_W + k] = c[i] ? c[k] : ~c[k];
            end
        end
        return u;
    endfunction

    // Stride permutation: bit j lands at (j*STRIDE) mod L
    function automatic logic [L-1:0] shuffle(input logic [L-1:0] u);
        logic [L-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < L; j++) begin
            s[LW'(j * STRIDE)] = u[j];
        end
        return s;
    endfunction

    state_t             r_state;
    state_t             w_nxt_state;
    logic [CHAOS_W-1:0] r_seed;
    logic [CHAOS_W-1:0] w_nxt_seed;
    logic               r_mode;
    logic               w_nxt_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_ready;
    logic               w_at_last;

    logic [OUT_W-1:0]   r_data;
    logic               r_valid;
    logic               r_last;

    logic [L-1:0]       w_u;
    logic [L-1:0]       w_e;
    logic [OUT_W-1:0]   w_beat;

    assign w_at_last = (r_cnt == CNT_W'(NB - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state, seed capture, beat counter advance and seed-accept strobe
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_seed  = r_seed;
        w_nxt_mode  = r_mode;
        w_nxt_cnt   = r_cnt;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_valid) begin
                    w_nxt_seed  = i_chaos;
                    w_nxt_mode  = i_mode;
                    w_nxt_cnt   = '0;
                    w_nxt_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    if (w_at_last) begin
                        // Last beat leaves: a waiting seed starts immediately
                        w_ready = 1'b1;
                        if (i_valid) begin
                            w_nxt_seed  = i_chaos;
                            w_nxt_mode  = i_mode;
                            w_nxt_cnt   = '0;
                            w_nxt_state = ST_SEND;
                        end else begin
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Expansion of the seed/mode/beat that will be current after this edge
    assign w_u    = expand_u(w_nxt_seed);
    assign w_e    = w_nxt_mode ? w_u : shuffle(w_u);
    assign w_beat = w_e[32'(w_nxt_cnt) * OUT_W +: OUT_W];

    // Seed, mode and beat counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seed <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_seed <= w_nxt_seed;
            r_mode <= w_nxt_mode;
            r_cnt  <= w_nxt_cnt;
        end
    end

    // Registered beat outputs; held unchanged while the sink stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= (w_nxt_state == ST_SEND);
            r_last  <= (w_nxt_state == ST_SEND) && (w_nxt_cnt == CNT_W'(NB - 1));
            r_data  <= (w_nxt_state == ST_SEND) ? w_beat : '0;
        end
    end

    assign o_ready = w_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: tb/tb_chaos_xpander_stream.sv
// Directed bench for chaos_xpander_stream (16-bit seed, 8-bit beats, stride 37),
// with a second STRIDE=1 instance sharing the same stimulus.
module tb_chaos_xpander_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_chaos;
    logic        i_mode;
    logic        i_valid;
    logic        i_ready;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_last;
    logic        o1_ready;
    logic [7:0]  o1_data;
    logic        o1_valid;
    logic        o1_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap  [32];
    logic [7:0] cap1 [32];
    logic [7:0] ref_a[32];
    logic [7:0] byp  [32];
    int         last_cnt;
    int         last_pos;

    always #5 clk = ~clk;

    chaos_xpander_stream #(.CHAOS_W(16), .OUT_W(8), .STRIDE(37)) dut (
        .i_clk(clk), .i_rst(rst), .i_chaos(i_chaos), .i_mode(i_mode),
        .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
        .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready)
    );

    chaos_xpander_stream #(.CHAOS_W(16), .OUT_W(8), .STRIDE(1)) dut_s1 (
        .i_clk(clk), .i_rst(rst), .i_chaos(i_chaos), .i_mode(i_mode),
        .i_valid(i_valid), .o_ready(o1_ready), .o_data(o1_data),
        .o_valid(o1_valid), .o_last(o1_last), .i_ready(i_ready)
    );

    typedef struct {
        logic [15:0] seed;
        logic        mode;
        int          beat;
        logic [7:0]  exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: output bit p of the shuffled vector is U at p*inv(37) mod 256, inv(37)=173
    function automatic logic [7:0] model_beat(input logic [15:0] c, input logic m,
                                              input bit stride1, input int b);
        logic [7:0] r;
        int p, j;
        for (int t = 0; t < 8; t++) begin
            p = b * 8 + t;
            j = (m || stride1) ? p : ((p * 173) % 256);
            r[t] = ~(c[j / 16] ^ c[j % 16]);
        end
        return r;
    endfunction

    // Send one seed, then collect 32 beats; rnd randomises i_ready and i_mode
    task automatic run_seq(input logic [15:0] seed, input logic mode, input bit rnd);
        int n, cyc;
        logic [7:0] pd;
        logic pl;
        bit pstall;
        @(posedge clk); #1;
        cyc = 0;
        while (!o_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_before_seed", 32'(o_ready), 32'd1);
        i_chaos = seed;
        i_mode  = mode;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_chaos = 16'($urandom);
        check("first_beat_latency", 32'(o_valid), 32'd1);
        n = 0; cyc = 0; pstall = 0; pd = '0; pl = 1'b0;
        last_cnt = 0; last_pos = -1;
        while (n < 32 && cyc < 1000) begin
            check("valid_mid_seq", 32'(o_valid), 32'd1);
            if (pstall) begin
                check("stall_data", 32'(o_data), 32'(pd));
                check("stall_last", 32'(o_last), 32'(pl));
            end
            i_ready = rnd ? 1'($urandom % 2) : 1'b1;
            if (rnd) i_mode = 1'($urandom);
            if (i_ready) begin
                cap[n]  = o_data;
                cap1[n] = o1_data;
                if (o_last) begin
                    last_cnt++;
                    last_pos = n;
                end
                n++;
            end
            pstall = !i_ready;
            pd = o_data;
            pl = o_last;
            @(posedge clk); #1;
            cyc++;
        end
        check("seq_complete", 32'(n), 32'd32);
        check("idle_after_seq", 32'(o_valid), 32'd0);
        check("last_count", 32'(last_cnt), 32'd1);
        check("last_pos", 32'(last_pos), 32'd31);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int   pop, ndiff, rdy_pos, rdy_cnt, n, cyc;

        vecs[0]  = '{16'h0001, 1'b1, 0,  8'h01};
        vecs[1]  = '{16'h0001, 1'b1, 1,  8'h00};
        vecs[2]  = '{16'h0001, 1'b1, 2,  8'hFE};
        vecs[3]  = '{16'h0001, 1'b1, 3,  8'hFF};
        vecs[4]  = '{16'h0001, 1'b1, 30, 8'hFE};
        vecs[5]  = '{16'h0001, 1'b1, 31, 8'hFF};
        vecs[6]  = '{16'h0001, 1'b0, 0,  8'hB7};
        vecs[7]  = '{16'hFFFF, 1'b1, 0,  8'hFF};
        vecs[8]  = '{16'hFFFF, 1'b1, 31, 8'hFF};
        vecs[9]  = '{16'hFFFF, 1'b0, 7,  8'hFF};
        vecs[10] = '{16'h0000, 1'b0, 0,  8'hFF};
        vecs[11] = '{16'h0000, 1'b1, 16, 8'hFF};
        vecs[12] = '{16'h0000, 1'b0, 31, 8'hFF};

        rst = 1'b1; i_chaos = '0; i_mode = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Table-driven single-beat vectors
        for (int i = 0; i < 13; i++) begin
            run_seq(vecs[i].seed, vecs[i].mode, 1'b0);
            check($sformatf("vec%0d_beat%0d", i, vecs[i].beat), 32'(cap[vecs[i].beat]), 32'(vecs[i].exp));
        end

        // Full bypass sequence against the model
        run_seq(16'h0001, 1'b1, 1'b0);
        for (int b = 0; b < 32; b++) begin
            byp[b] = cap[b];
            check($sformatf("byp_beat%0d", b), 32'(cap[b]), 32'(model_beat(16'h0001, 1'b1, 1'b0, b)));
        end

        // Shuffled sequence: model, popcount, differs from bypass; STRIDE=1 equals bypass
        run_seq(16'h0001, 1'b0, 1'b0);
        pop = 0; ndiff = 0;
        for (int b = 0; b < 32; b++) begin
            check($sformatf("shuf_beat%0d", b), 32'(cap[b]), 32'(model_beat(16'h0001, 1'b0, 1'b0, b)));
            check($sformatf("s1_beat%0d", b), 32'(cap1[b]), 32'(byp[b]));
            pop += $countones(cap[b]);
            if (cap[b] != byp[b]) ndiff++;
        end
        check("shuf_popcount", 32'(pop), 32'd226);
        check("shuf_differs", 32'(ndiff != 0), 32'd1);

        // Degenerate seeds in both modes give all-ones
        for (int s = 0; s < 4; s++) begin
            run_seq((s < 2) ? 16'hFFFF : 16'h0000, 1'(s % 2), 1'b0);
            for (int b = 0; b < 32; b++)
                check($sformatf("ones_s%0d_b%0d", s, b), 32'(cap[b]), 32'hFF);
        end

        // Backpressure: random stalls must reproduce the free-flowing sequence
        run_seq(16'hA5C3, 1'b0, 1'b0);
        for (int b = 0; b < 32; b++) begin
            ref_a[b] = cap[b];
            check($sformatf("a5_beat%0d", b), 32'(cap[b]), 32'(model_beat(16'hA5C3, 1'b0, 1'b0, b)));
        end
        run_seq(16'hA5C3, 1'b0, 1'b1);
        for (int b = 0; b < 32; b++)
            check($sformatf("bp_beat%0d", b), 32'(cap[b]), 32'(ref_a[b]));

        // Reset in the middle of a sequence at beat 5
        @(posedge clk); #1;
        i_chaos = 16'h0001; i_mode = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_beat5", 32'(o_data), 32'hFF);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_last",  32'(o_last),  32'd0);
        check("mid_rst_data",  32'(o_data),  32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        run_seq(16'h0001, 1'b1, 1'b0);
        check("restart_beat0", 32'(cap[0]), 32'h01);
        check("restart_beat1", 32'(cap[1]), 32'h00);

        // Back-to-back: second seed waits and is taken on the final handshake
        @(posedge clk); #1;
        i_chaos = 16'h0001; i_mode = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_chaos = 16'hA5C3; i_mode = 1'b0;
        rdy_pos = -1; rdy_cnt = 0; n = 0; cyc = 0;
        while (n < 32 && cyc < 200) begin
            if (o_ready) begin
                rdy_cnt++;
                rdy_pos = n;
            end
            if (o_valid) begin
                cap[n] = o_data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_valid = 1'b0;
        i_chaos = 16'h0;
        check("b2b_ready_count", 32'(rdy_cnt), 32'd1);
        check("b2b_ready_pos", 32'(rdy_pos), 32'd31);
        check("b2b_first_beat31", 32'(cap[31]), 32'hFF);
        check("b2b_no_bubble", 32'(o_valid), 32'd1);
        check("b2b_seed2_beat0", 32'(o_data), 32'(model_beat(16'hA5C3, 1'b0, 1'b0, 0)));
        check("b2b_seed2_last0", 32'(o_last), 32'd0);
        n = 0; cyc = 0;
        while (n < 32 && cyc < 200) begin
            if (o_valid) begin
                cap[n] = o_data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_seed2_count", 32'(n), 32'd32);
        for (int b = 0; b < 32; b++)
            check($sformatf("b2b_s2_beat%0d", b), 32'(cap[b]), 32'(ref_a[b]));
        check("b2b_idle_after", 32'(o_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chaos_xpander_stream.md
Name: chaos_xpander_stream

Overview:
- Parametrised, sequential successor to the 16-to-256 chaos expander.
- Accepts a CHAOS_W-bit chaos seed over a valid/ready handshake and builds the CHAOS_W*CHAOS_W-bit self-modulated sequence.
- Optionally applies a stride permutation, then streams the result as OUT_W-bit beats with backpressure and a last-beat flag.
- Sits between the chaos generator and the DCSK modulator's reference/data slot builder.

Parameters:
- CHAOS_W, 16, seed width; power of two, >= 4.
- OUT_W, 8, output beat width; must divide L = CHAOS_W*CHAOS_W.
- STRIDE, 37, permutation multiplier; must be odd (so it is coprime to L). An elaboration-time error is raised if this rule or the OUT_W rule is violated.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_chaos  input  CHAOS_W  chaos seed.
- i_mode  input  1  0 = shuffled output, 1 = unshuffled bypass; sampled together with the seed.
- i_valid  input  1  seed valid.
- o_ready  output  1  seed accept.
- o_data  output  OUT_W  current beat.
- o_valid  output  1  beat valid.
- o_last  output  1  final beat of the sequence.
- i_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert; deassert synchronised by the integrator):
  - State = IDLE; seed and mode registers = 0; beat counter = 0.
  - o_valid = 0, o_last = 0, o_data = 0, o_ready = 1.
- Expansion, for stored seed C and L = CHAOS_W^2:
  - Unshuffled vector: U[i*CHAOS_W + k] = C[i] ? C[k] : ~C[k], for all i, k in 0..CHAOS_W-1. Every row is populated, including row CHAOS_W-1.
  - Shuffled vector: S[(j*STRIDE) mod L] = U[j], for j in 0..L-1. The mod is the natural truncation to log2(L) bits.
  - Emitted vector: E = mode ? U : S.
  - Beat b: o_data = E[b*OUT_W +: OUT_W], for b = 0..NB-1, where NB = L/OUT_W.
- States:
  - IDLE: o_ready = 1, o_valid = 0. On i_valid, latch i_chaos and i_mode, clear the counter, go to SEND.
  - SEND: o_valid = 1; o_data and o_last are registered/derived from the stored seed and counter. o_last = (b == NB-1).
    - i_ready = 1 and b < NB-1: increment b.
    - i_ready = 1 and b == NB-1: sequence done.
    - i_ready = 0: hold o_data, o_last and b stable (AXI-stream rules).
    - o_valid never drops mid-sequence.
- Latency: a seed accepted at edge T gives its first beat valid in the cycle after T; no combinational path from i_valid to o_valid.
- Back-to-back:
  - In SEND, o_ready = 1 only in the last-beat cycle with i_ready = 1; otherwise o_ready = 0.
  - If a new seed is accepted on that edge, stay in SEND with b = 0 and the new seed/mode: zero-bubble streaming.
  - Otherwise go to IDLE.
- Seeds presented while o_ready = 0 are not consumed; the source holds them.
- Mode is per-sequence; i_mode changes during SEND have no effect.
- Reset mid-sequence: the stream is aborted immediately, the partial sequence is discarded and outputs return to their reset values. No o_last is emitted.
- Seed 0 and seed all-ones are legal (both expand to all-ones).

Test Plan:
- Reset: assert i_rst mid-SEND at beat 5 -> o_valid = 0, o_last = 0, o_data = 0 asynchronously; o_ready = 1; the next seed restarts at beat 0.
- Bypass, seed 16'h0001, mode = 1, i_ready = 1 -> 32 beats:
  - Beat 0 = 8'h01, beat 1 = 8'h00, beats 2..31 alternate 8'hFE, 8'hFF.
  - o_last only on beat 31; first beat one cycle after accept.
- Shuffled, seed 16'h0001, mode = 0 -> 32 beats:
  - Total popcount 226.
  - Bits match the scoreboard model S[(37*j) mod 256] = U[j].
  - Beat set differs from the bypass run.
- Seed 16'hFFFF and seed 16'h0000, each mode -> all 32 beats = 8'hFF.
- Backpressure: random i_ready (50%) with seed 16'hA5C3 -> o_data and o_last stable while stalled; the sequence equals the i_ready = 1 run; no beat lost or duplicated.
- Back-to-back:
  - Second seed held valid during the first sequence -> accepted exactly on the beat-31 handshake, next cycle beat 0 of seed 2, no idle cycle.
  - With STRIDE = 1 build, shuffled output equals bypass output.
